// File: rtl/tri_pixel_buffer_if.sv
// Pixel-stream and row-drain bundle between the rasterizer, tri_pixel_buffer and the display stage.
// The master side drives the pixel stream and out_ready; the slave side is the buffer.
interface tri_pixel_buffer_if;
  logic       busy_in;
  logic       po;
  logic [2:0] xi;
  logic [2:0] yi;
  logic       hold;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] row_addr;
  logic [7:0] row_data;
  logic [6:0] pix_cnt;
  logic [3:0] dup_cnt;
  logic       frame_done;
  logic       drop_err;
  logic [2:0] xmin;
  logic [2:0] xmax;
  logic [2:0] ymin;
  logic [2:0] ymax;

  modport master (
    output busy_in, po, xi, yi, out_ready,
    input  hold, out_valid, row_addr, row_data, pix_cnt, dup_cnt,
           frame_done, drop_err, xmin, xmax, ymin, ymax
  );

  modport slave (
    input  busy_in, po, xi, yi, out_ready,
    output hold, out_valid, row_addr, row_data, pix_cnt, dup_cnt,
           frame_done, drop_err, xmin, xmax, ymin, ymax
  );
endinterface

// File: rtl/tri_pixel_buffer.sv
// Captures one triangle's pixel stream into an 8x8 bitmap, then drains it row by row.
// Optional bounding-box tracking is built when TRI_BBOX_EN is defined; otherwise bbox ports read 0.
module tri_pixel_buffer (
  input logic              clk,
  input logic              reset,
  tri_pixel_buffer_if.slave bus
);
  // state   | meaning
  // IDLE    | results held, waiting for busy_in rising edge
  // COLLECT | capturing pixels while the rasterizer is busy
  // TAIL    | one extra capture cycle for the final pixel
  // DRAIN   | presenting rows 0..7 over valid/ready, hold raised
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_TAIL, S_DRAIN} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_busy_d;
  logic [7:0][7:0] r_bitmap;
  logic [6:0]      r_pix_cnt;
  logic [3:0]      r_dup_cnt;
  logic [2:0]      r_row_addr;
  logic            r_frame_done;
  logic            r_drop_err;

  logic            w_rise, w_fall, w_clear, w_cap, w_xfer, w_last, w_bit;
  logic [6:0]      w_pix_base;

  assign w_rise = bus.busy_in & ~r_busy_d;
  assign w_fall = ~bus.busy_in & r_busy_d;

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_cap       = 1'b0;
    w_xfer      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_clear     = 1'b1;
          w_cap       = bus.po;
          w_state_nxt = S_COLLECT;
        end
      end
      S_COLLECT: begin
        w_cap = bus.po;
        if (w_fall) w_state_nxt = S_TAIL;
      end
      S_TAIL: begin
        w_cap       = bus.po;
        w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_xfer = bus.out_ready;
        if (bus.out_ready && (r_row_addr == 3'd7)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_last = w_xfer && (r_row_addr == 3'd7);

  // A pixel in the frame-start cycle sees the bitmap and counters as already cleared.
  assign w_bit      = w_clear ? 1'b0 : r_bitmap[bus.yi][bus.xi];
  assign w_pix_base = w_clear ? 7'd0 : r_pix_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy_d     <= 1'b0;
      r_bitmap     <= '0;
      r_pix_cnt    <= '0;
      r_dup_cnt    <= '0;
      r_row_addr   <= '0;
      r_frame_done <= 1'b0;
      r_drop_err   <= 1'b0;
    end else begin
      r_busy_d     <= bus.busy_in;
      r_frame_done <= w_last;
      if (w_clear) begin
        r_bitmap  <= '0;
        r_pix_cnt <= '0;
        r_dup_cnt <= '0;
      end
      if (w_cap) begin
        if (!w_bit) begin
          r_bitmap[bus.yi][bus.xi] <= 1'b1;
          r_pix_cnt                <= w_pix_base + 7'd1;
        end else if (r_dup_cnt != 4'd15) begin
          r_dup_cnt <= r_dup_cnt + 4'd1;
        end
      end
      if (w_xfer) r_row_addr <= r_row_addr + 3'd1;
      if ((r_state == S_DRAIN) && bus.po) r_drop_err <= 1'b1;
    end
  end

  assign bus.hold       = (r_state == S_DRAIN);
  assign bus.out_valid  = (r_state == S_DRAIN);
  assign bus.row_addr   = r_row_addr;
  assign bus.row_data   = r_bitmap[r_row_addr];
  assign bus.pix_cnt    = r_pix_cnt;
  assign bus.dup_cnt    = r_dup_cnt;
  assign bus.frame_done = r_frame_done;
  assign bus.drop_err   = r_drop_err;

`ifdef TRI_BBOX_EN
  logic [2:0] r_xmin, r_xmax, r_ymin, r_ymax;
  logic [2:0] w_xmin_b, w_xmax_b, w_ymin_b, w_ymax_b;

  assign w_xmin_b = w_clear ? 3'd7 : r_xmin;
  assign w_xmax_b = w_clear ? 3'd0 : r_xmax;
  assign w_ymin_b = w_clear ? 3'd7 : r_ymin;
  assign w_ymax_b = w_clear ? 3'd0 : r_ymax;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_xmin <= '0;
      r_xmax <= '0;
      r_ymin <= '0;
      r_ymax <= '0;
    end else if (w_clear || (w_cap && !w_bit)) begin
      r_xmin <= (w_cap && !w_bit && (bus.xi < w_xmin_b)) ? bus.xi : w_xmin_b;
      r_xmax <= (w_cap && !w_bit && (bus.xi > w_xmax_b)) ? bus.xi : w_xmax_b;
      r_ymin <= (w_cap && !w_bit && (bus.yi < w_ymin_b)) ? bus.yi : w_ymin_b;
      r_ymax <= (w_cap && !w_bit && (bus.yi > w_ymax_b)) ? bus.yi : w_ymax_b;
    end
  end

  assign bus.xmin = r_xmin;
  assign bus.xmax = r_xmax;
  assign bus.ymin = r_ymin;
  assign bus.ymax = r_ymax;
`else
  assign bus.xmin = '0;
  assign bus.xmax = '0;
  assign bus.ymin = '0;
  assign bus.ymax = '0;
`endif
endmodule

// File: tb/tb_tri_pixel_buffer.sv
// Directed bench for tri_pixel_buffer: a bitmap model pushes expected rows into a queue,
// which are popped and compared on each row handshake.
module tb_tri_pixel_buffer;
  logic clk = 1'b0;
  logic reset = 1'b1;

  tri_pixel_buffer_if bus ();

  tri_pixel_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  m_bm [8];
  int          m_pix;
  int          m_dup;
  logic [2:0]  m_xmin, m_xmax, m_ymin, m_ymax;
  logic [10:0] q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bbox();
`ifdef TRI_BBOX_EN
    check("xmin", bus.xmin, m_xmin);
    check("xmax", bus.xmax, m_xmax);
    check("ymin", bus.ymin, m_ymin);
    check("ymax", bus.ymax, m_ymax);
`else
    check("bbox_tied", {bus.xmin, bus.xmax, bus.ymin, bus.ymax}, 0);
`endif
  endtask

  task automatic model_reset();
    for (int r = 0; r < 8; r++) m_bm[r] = 8'h00;
    m_pix = 0; m_dup = 0;
    m_xmin = 0; m_xmax = 0; m_ymin = 0; m_ymax = 0;
  endtask

  task automatic model_clear();
    for (int r = 0; r < 8; r++) m_bm[r] = 8'h00;
    m_pix = 0; m_dup = 0;
    m_xmin = 7; m_xmax = 0; m_ymin = 7; m_ymax = 0;
  endtask

  task automatic model_pix(input logic [2:0] x, input logic [2:0] y);
    if (!m_bm[y][x]) begin
      m_bm[y][x] = 1'b1;
      m_pix++;
      if (x < m_xmin) m_xmin = x;
      if (x > m_xmax) m_xmax = x;
      if (y < m_ymin) m_ymin = y;
      if (y > m_ymax) m_ymax = y;
    end else if (m_dup < 15) begin
      m_dup++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_hold"},       bus.hold, 0);
    check({tag, "_out_valid"},  bus.out_valid, 0);
    check({tag, "_row_addr"},   bus.row_addr, 0);
    check({tag, "_row_data"},   bus.row_data, 0);
    check({tag, "_pix_cnt"},    bus.pix_cnt, 0);
    check({tag, "_dup_cnt"},    bus.dup_cnt, 0);
    check({tag, "_frame_done"}, bus.frame_done, 0);
    check({tag, "_drop_err"},   bus.drop_err, 0);
    check({tag, "_bbox"}, {bus.xmin, bus.xmax, bus.ymin, bus.ymax}, 0);
  endtask

  task automatic start_frame(input bit with_pix, input logic [2:0] x, input logic [2:0] y);
    model_clear();
    bus.busy_in = 1'b1;
    bus.po = with_pix; bus.xi = x; bus.yi = y;
    tick();
    bus.po = 1'b0;
    if (with_pix) model_pix(x, y);
  endtask

  task automatic pixel(input logic [2:0] x, input logic [2:0] y);
    bus.po = 1'b1; bus.xi = x; bus.yi = y;
    tick();
    bus.po = 1'b0;
    model_pix(x, y);
  endtask

  task automatic end_frame(input bit tail_pix, input logic [2:0] x, input logic [2:0] y);
    logic [2:0] ra;
    bus.busy_in = 1'b0;
    tick();
    bus.po = tail_pix; bus.xi = x; bus.yi = y;
    tick();
    bus.po = 1'b0;
    if (tail_pix) model_pix(x, y);
    for (int r = 0; r < 8; r++) begin
      ra = r[2:0];
      q.push_back({ra, m_bm[r]});
    end
  endtask

  // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0 repeating.
  task automatic drain(input int mode, input bit inject, input int abort_row);
    int rows;
    bit rdy;
    logic [10:0] exp;
    rows = 0;
    for (int cyc = 0; cyc < 64 && rows < 8; cyc++) begin
      if (abort_row >= 0 && rows == abort_row) break;
      rdy = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      bus.out_ready = rdy;
      bus.po = inject && (cyc == 0); bus.xi = 3'd0; bus.yi = 3'd0;
      check("drain_hold", bus.hold, 1);
      check("drain_valid", bus.out_valid, 1);
      exp = q[0];
      check("row_addr", bus.row_addr, exp[10:8]);
      check("row_data", bus.row_data, exp[7:0]);
      if (rdy) begin
        void'(q.pop_front());
        rows++;
      end
      tick();
    end
    bus.po = 1'b0;
    bus.out_ready = 1'b0;
    if (abort_row < 0) begin
      check("drain_rows_done", rows, 8);
      check("frame_done_pulse", bus.frame_done, 1);
      check("idle_hold", bus.hold, 0);
      check("idle_valid", bus.out_valid, 0);
      check("idle_row_addr", bus.row_addr, 0);
      check("idle_row0_held", bus.row_data, m_bm[0]);
      check("pix_cnt", bus.pix_cnt, m_pix);
      check("dup_cnt", bus.dup_cnt, m_dup);
      check_bbox();
      tick();
      check("frame_done_clear", bus.frame_done, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.busy_in = 1'b0; bus.po = 1'b0; bus.xi = 3'd0; bus.yi = 3'd0; bus.out_ready = 1'b0;
    model_reset();
    tick(); tick();
    check_reset_vals("reset");
    reset = 1'b0;
    tick();

    // Frame A: small triangle, full-rate drain.
    start_frame(1'b0, 3'd0, 3'd0);
    pixel(3'd1, 3'd1);
    pixel(3'd2, 3'd1);
    pixel(3'd1, 3'd2);
    end_frame(1'b0, 3'd0, 3'd0);
    check("a_pix_cnt", bus.pix_cnt, 3);
    drain(0, 1'b0, -1);

    // Frame B: duplicates, saturation, pixel captured in TAIL, stalled drain.
    start_frame(1'b0, 3'd0, 3'd0);
    for (int i = 0; i < 3; i++) pixel(3'd3, 3'd3);
    check("b_pix_one", bus.pix_cnt, 1);
    check("b_dup_two", bus.dup_cnt, 2);
    for (int i = 0; i < 20; i++) pixel(3'd3, 3'd3);
    check("b_dup_sat", bus.dup_cnt, 15);
    end_frame(1'b1, 3'd5, 3'd4);
    check("b_row4_tail", m_bm[4], 8'h20);
    drain(1, 1'b0, -1);

    // Frame C: bounding box and a pixel dropped during DRAIN.
    start_frame(1'b0, 3'd0, 3'd0);
    pixel(3'd2, 3'd5);
    pixel(3'd6, 3'd1);
    end_frame(1'b0, 3'd0, 3'd0);
    check_bbox();
    drain(0, 1'b1, -1);
    check("c_drop_err", bus.drop_err, 1);

    // Frame D: pixel in the start cycle, then reset during DRAIN at row 3.
    start_frame(1'b1, 3'd7, 3'd7);
    check("d_drop_sticky", bus.drop_err, 1);
    pixel(3'd0, 3'd6);
    end_frame(1'b0, 3'd0, 3'd0);
    check("d_pix_cnt", bus.pix_cnt, 2);
    check_bbox();
    drain(0, 1'b0, 3);
    check("d_at_row3", bus.row_addr, 3);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("async_reset");
    q.delete();
    model_reset();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_frame_done", bus.frame_done, 0);
    end
    check_reset_vals("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
